// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - shared types, defaults and helpers for the SRAM request controller
package sram_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        RESP  = 2'd3
    } sram_ctrl_state_t;

    localparam int SRAM_WIDTH      = 16;
    localparam int SRAM_DEPTH      = 1024;
    localparam int SRAM_RD_LATENCY = 2;

    function automatic int addr_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/sram_req_ctrl.sv
// rtl/sram_req_ctrl.sv - single-outstanding request/response front-end for the banked SRAM
module sram_req_ctrl
    import sram_pkg::*;
#(
    parameter int WIDTH      = SRAM_WIDTH,
    parameter int DEPTH      = SRAM_DEPTH,
    parameter int RD_LATENCY = SRAM_RD_LATENCY,
    localparam int AW        = addr_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [AW-1:0]    req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_rdata,
    output logic             mem_wren,
    output logic             mem_rden,
    output logic [AW-1:0]    mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rd_data
);

    // Counter is wide enough for the full 1..15 latency range.
    localparam logic [3:0] LAT_LAST = 4'(RD_LATENCY - 1);

    sram_ctrl_state_t state, state_nxt;

    logic [3:0]       lat_cnt, lat_cnt_nxt;
    logic             mem_wren_nxt;
    logic             mem_rden_nxt;
    logic [AW-1:0]    mem_addr_nxt;
    logic [WIDTH-1:0] mem_wdata_nxt;
    logic             rsp_valid_nxt;
    logic [WIDTH-1:0] rsp_rdata_nxt;

    // Acceptance depends only on the current state, so a request raised during
    // the RESP->IDLE cycle waits one more cycle.
    assign req_ready = (state == IDLE) && rstn;

    // State register.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    state_nxt = req_we ? WRITE : READ;
                end
            end
            WRITE: state_nxt = IDLE;
            READ: begin
                if (lat_cnt == LAT_LAST) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Next values of the registered outputs; strobes default low, data holds.
    always_comb begin
        mem_wren_nxt  = 1'b0;
        mem_rden_nxt  = 1'b0;
        mem_addr_nxt  = mem_addr;
        mem_wdata_nxt = mem_wdata;
        rsp_valid_nxt = rsp_valid;
        rsp_rdata_nxt = rsp_rdata;
        lat_cnt_nxt   = lat_cnt;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    mem_addr_nxt  = req_addr;
                    mem_wdata_nxt = req_wdata;
                    if (req_we) begin
                        mem_wren_nxt = 1'b1;
                    end else begin
                        mem_rden_nxt = 1'b1;
                        lat_cnt_nxt  = 4'd0;
                    end
                end
            end
            WRITE: begin
                mem_wren_nxt = 1'b0;
            end
            READ: begin
                if (lat_cnt == LAT_LAST) begin
                    rsp_rdata_nxt = mem_rd_data;
                    rsp_valid_nxt = 1'b1;
                end else begin
                    mem_rden_nxt = 1'b1;
                end
                lat_cnt_nxt = lat_cnt + 4'd1;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_nxt = 1'b0;
                end
            end
            default: begin
                mem_wren_nxt = 1'b0;
            end
        endcase
    end

    // Output and counter registers; reset abandons any in-flight transaction.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            mem_wren  <= 1'b0;
            mem_rden  <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            lat_cnt   <= 4'd0;
        end else begin
            mem_wren  <= mem_wren_nxt;
            mem_rden  <= mem_rden_nxt;
            mem_addr  <= mem_addr_nxt;
            mem_wdata <= mem_wdata_nxt;
            rsp_valid <= rsp_valid_nxt;
            rsp_rdata <= rsp_rdata_nxt;
            lat_cnt   <= lat_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_sram_req_ctrl.sv
// tb/tb_sram_req_ctrl.sv - directed table-driven bench for sram_req_ctrl
module tb_sram_req_ctrl;

    localparam int WIDTH = 16;
    localparam int DEPTH = 1024;
    localparam int AW    = 10;
    localparam int RDL   = 2;

    logic             clk;
    logic             rstn;
    logic             req_valid;
    logic             req_ready;
    logic             req_we;
    logic [AW-1:0]    req_addr;
    logic [WIDTH-1:0] req_wdata;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_rdata;
    logic             mem_wren;
    logic             mem_rden;
    logic [AW-1:0]    mem_addr;
    logic [WIDTH-1:0] mem_wdata;
    logic [WIDTH-1:0] mem_rd_data;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    sram_req_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RD_LATENCY(RDL)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .mem_wren   (mem_wren),
        .mem_rden   (mem_rden),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rd_data(mem_rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // SRAM model: data only becomes valid once rden has been held RDL cycles.
    logic [WIDTH-1:0] mem [DEPTH];
    int rcnt = 0;
    always @(posedge clk) begin
        if (mem_wren === 1'b1) mem[mem_addr] <= mem_wdata;
        if (mem_rden === 1'b1) begin
            mem_rd_data <= (rcnt == RDL - 2) ? mem[mem_addr] : 16'hDEAD;
            rcnt <= rcnt + 1;
        end else begin
            mem_rd_data <= 16'hDEAD;
            rcnt <= 0;
        end
    end

    // Strobes must be mutually exclusive at all times.
    always @(negedge clk) begin
        n_checks++;
        if (mem_wren === 1'b1 && mem_rden === 1'b1) begin
            n_fail++;
            $display("FAIL strobe_exclusive: wren=%b rden=%b required not both 1 (cycle %0d)", mem_wren, mem_rden, cyc);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 20; i++) begin
            if (req_ready) break;
            step();
        end
        chk("req_ready_wait", {31'd0, req_ready}, 32'd1);
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = a;
        req_wdata = d;
        wait_ready();
        step();
        req_valid = 1'b0;
        chk("wr_wren_on", {31'd0, mem_wren}, 32'd1);
        chk("wr_addr", {22'd0, mem_addr}, {22'd0, a});
        chk("wr_data", {16'd0, mem_wdata}, {16'd0, d});
        chk("wr_busy", {31'd0, req_ready}, 32'd0);
        step();
        chk("wr_wren_off", {31'd0, mem_wren}, 32'd0);
        chk("wr_idle_ready", {31'd0, req_ready}, 32'd1);
    endtask

    // Issues a read and checks up to the cycle rsp_valid rises; if complete is
    // set the response is consumed (rsp_ready must already be 1).
    task automatic do_read(input logic [AW-1:0] a, input logic [WIDTH-1:0] e, input bit complete);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = a;
        req_wdata = 16'h0BAD;
        wait_ready();
        step();
        req_valid = 1'b0;
        for (int k = 0; k < RDL; k++) begin
            chk("rd_rden_on", {31'd0, mem_rden}, 32'd1);
            chk("rd_addr", {22'd0, mem_addr}, {22'd0, a});
            chk("rd_no_rsp_yet", {31'd0, rsp_valid}, 32'd0);
            step();
        end
        chk("rd_rden_off", {31'd0, mem_rden}, 32'd0);
        chk("rd_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("rd_rdata", {16'd0, rsp_rdata}, {16'd0, e});
        if (complete) begin
            step();
            chk("rd_rsp_done", {31'd0, rsp_valid}, 32'd0);
            chk("rd_idle_ready", {31'd0, req_ready}, 32'd1);
        end
    endtask

    typedef struct {
        bit               we;
        logic [AW-1:0]    addr;
        logic [WIDTH-1:0] data;
    } vec_t;

    vec_t vecs[10];
    int   hs[4];

    initial begin
        vecs[0] = '{1'b1, 10'h005, 16'hA5A5};
        vecs[1] = '{1'b0, 10'h005, 16'hA5A5};
        vecs[2] = '{1'b1, 10'h000, 16'h1111};
        vecs[3] = '{1'b1, 10'h100, 16'h2222};
        vecs[4] = '{1'b1, 10'h200, 16'h3333};
        vecs[5] = '{1'b1, 10'h3FF, 16'h4444};
        vecs[6] = '{1'b0, 10'h3FF, 16'h4444};
        vecs[7] = '{1'b0, 10'h200, 16'h3333};
        vecs[8] = '{1'b0, 10'h100, 16'h2222};
        vecs[9] = '{1'b0, 10'h000, 16'h1111};

        rstn      = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        rsp_ready = 1'b1;
        repeat (3) step();

        chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_wren", {31'd0, mem_wren}, 32'd0);
        chk("rst_rden", {31'd0, mem_rden}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_addr", {22'd0, mem_addr}, 32'd0);
        chk("rst_wdata", {16'd0, mem_wdata}, 32'd0);
        chk("rst_rdata", {16'd0, rsp_rdata}, 32'd0);

        rstn = 1'b1;
        #1;
        chk("post_rst_ready", {31'd0, req_ready}, 32'd1);

        for (int i = 0; i < 10; i++) begin
            if (vecs[i].we) do_write(vecs[i].addr, vecs[i].data);
            else            do_read(vecs[i].addr, vecs[i].data, 1'b1);
        end

        // Backpressure: response must hold while rsp_ready stays low.
        rsp_ready = 1'b0;
        do_read(10'h3FF, 16'h4444, 1'b0);
        for (int k = 0; k < 10; k++) begin
            step();
            chk("bp_valid_hold", {31'd0, rsp_valid}, 32'd1);
            chk("bp_rdata_hold", {16'd0, rsp_rdata}, 32'h4444);
            chk("bp_not_ready", {31'd0, req_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        step();
        chk("bp_release_valid", {31'd0, rsp_valid}, 32'd0);
        chk("bp_release_ready", {31'd0, req_ready}, 32'd1);

        // Back-to-back with req_valid held high: W, R, W, R.
        req_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_we    = (i % 2 == 0);
            req_addr  = 10'h010 + 10'(i / 2);
            req_wdata = (i / 2 == 0) ? 16'h1234 : 16'h5678;
            wait_ready();
            hs[i] = cyc;
            step();
        end
        req_valid = 1'b0;
        chk("b2b_wr_to_rd", 32'(hs[1] - hs[0]), 32'd2);
        chk("b2b_rd_to_wr", 32'(hs[2] - hs[1]), 32'(RDL + 2));
        chk("b2b_wr_to_rd2", 32'(hs[3] - hs[2]), 32'd2);
        for (int k = 0; k < 10; k++) begin
            if (rsp_valid) break;
            step();
        end
        chk("b2b_last_valid", {31'd0, rsp_valid}, 32'd1);
        chk("b2b_last_rdata", {16'd0, rsp_rdata}, 32'h5678);
        step();

        // Reset during the first READ cycle abandons the read.
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 10'h100;
        wait_ready();
        step();
        req_valid = 1'b0;
        chk("mid_rden_before", {31'd0, mem_rden}, 32'd1);
        rstn = 1'b0;
        #1;
        chk("mid_ready_in_rst", {31'd0, req_ready}, 32'd0);
        step();
        chk("mid_rden", {31'd0, mem_rden}, 32'd0);
        chk("mid_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("mid_rdata", {16'd0, rsp_rdata}, 32'd0);
        chk("mid_addr", {22'd0, mem_addr}, 32'd0);
        chk("mid_ready", {31'd0, req_ready}, 32'd0);
        rstn = 1'b1;
        step();
        chk("mid_after_ready", {31'd0, req_ready}, 32'd1);
        for (int k = 0; k < 6; k++) begin
            chk("mid_no_spurious", {30'd0, rsp_valid, mem_rden}, 32'd0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
